// File: rtl/draw_scheduler_pkg.sv
// Shared screen geometry, colour codes and FSM encoding for the per-frame draw scheduler.
package draw_scheduler_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int FB_PIXELS   = SCREEN_W * SCREEN_H;
   localparam int FB_MIN_ADDR = 5 * SCREEN_W;

   localparam logic [2:0] COLOR_BLACK = 3'b000;
   localparam logic [2:0] COLOR_BLUE  = 3'b001;
   localparam logic [2:0] COLOR_GREEN = 3'b010;
   localparam logic [2:0] COLOR_RED   = 3'b100;
   localparam logic [2:0] COLOR_WHITE = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_ARB    = 3'd2,
      S_LAUNCH = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } schedState_t;

   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Bundle of requester, drawer, framebuffer and status signals around the draw scheduler.
interface draw_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 19,
   parameter int COLOR_W = 3
);
   logic                       frame_start;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr;
   logic [NUM_REQ*COLOR_W-1:0] req_color;
   logic [NUM_REQ-1:0]         grant;
   logic                       draw_start;
   logic [ADDR_W-1:0]          draw_addr;
   logic [COLOR_W-1:0]         draw_color;
   logic                       draw_done;
   logic [ADDR_W-1:0]          drw_waddr;
   logic                       drw_wenable;
   logic [ADDR_W-1:0]          mem_waddr;
   logic [COLOR_W-1:0]         mem_wdata;
   logic                       mem_wenable;
   logic                       frame_busy;
   logic                       frame_done;
   logic                       err_overrun;
   logic                       err_bounds;
   logic                       err_timeout;

   // The scheduler side owns grants, the drawer launch and the framebuffer port
   modport master (
      input  frame_start, req, req_addr, req_color, draw_done, drw_waddr, drw_wenable,
      output grant, draw_start, draw_addr, draw_color, mem_waddr, mem_wdata, mem_wenable,
      output frame_busy, frame_done, err_overrun, err_bounds, err_timeout
   );

   modport slave (
      output frame_start, req, req_addr, req_color, draw_done, drw_waddr, drw_wenable,
      input  grant, draw_start, draw_addr, draw_color, mem_waddr, mem_wdata, mem_wenable,
      input  frame_busy, frame_done, err_overrun, err_bounds, err_timeout
   );

endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin picker; the last-grant pointer lives in the scheduler.
module rr_arbiter
   import draw_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idxWidth(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_pending,
   input  logic [IDX_W-1:0]   i_lastGrant,
   output logic [NUM_REQ-1:0] o_pick,
   output logic [IDX_W-1:0]   o_pickIdx
);

   // Scan starts just past the previous winner so every requester gets a turn
   always_comb begin : scan
      logic             found;
      logic [IDX_W-1:0] cand;
      found     = 1'b0;
      cand      = '0;
      o_pick    = '0;
      o_pickIdx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(i_lastGrant) + k) % NUM_REQ);
         if (!found && i_pending[cand]) begin
            found        = 1'b1;
            o_pick[cand] = 1'b1;
            o_pickIdx    = cand;
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: optional framebuffer clear, round-robin sprite launches, and sole
// ownership of the framebuffer write port.
module draw_scheduler
   import draw_scheduler_pkg::*;
#(
   parameter int                 NUM_REQ   = 4,
   parameter int                 ADDR_W    = 19,
   parameter int                 COLOR_W   = 3,
   parameter int                 SCREEN_PX = FB_PIXELS,
   parameter int                 MIN_ADDR  = FB_MIN_ADDR,
   parameter logic [COLOR_W-1:0] BG_COLOR  = COLOR_W'(COLOR_BLACK),
   parameter bit                 CLEAR_EN  = 1'b1,
   parameter int                 WATCHDOG  = 1024
)(
   input  logic          clock,
   input  logic          resetn,
   draw_scheduler_if.master bus
);

   localparam int IDX_W = idxWidth(NUM_REQ);
   localparam int WD_W  = $clog2(WATCHDOG + 1);

   localparam logic [ADDR_W-1:0] L_MIN      = ADDR_W'(MIN_ADDR);
   localparam logic [ADDR_W-1:0] L_LIMIT    = ADDR_W'(SCREEN_PX);
   localparam logic [ADDR_W-1:0] L_CLR_LAST = ADDR_W'(SCREEN_PX - 1);
   localparam logic [WD_W-1:0]   L_WD_LAST  = WD_W'(WATCHDOG - 1);
   localparam logic [IDX_W-1:0]  L_LAST_REQ = IDX_W'(NUM_REQ - 1);

   schedState_t        r_state;
   logic [NUM_REQ-1:0] r_pending;
   logic [IDX_W-1:0]   r_lastGrant;
   logic [ADDR_W-1:0]  r_clrAddr;
   logic [WD_W-1:0]    r_waitCnt;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_drawStart;
   logic [ADDR_W-1:0]  r_drawAddr;
   logic [COLOR_W-1:0] r_drawColor;
   logic               r_frameBusy;
   logic               r_frameDone;
   logic               r_errOverrun;
   logic               r_errBounds;
   logic               r_errTimeout;
   logic [ADDR_W-1:0]  r_memWaddr;
   logic [COLOR_W-1:0] r_memWdata;
   logic               r_memWen;

   logic [NUM_REQ-1:0] w_pick;
   logic [IDX_W-1:0]   w_pickIdx;
   logic [ADDR_W-1:0]  w_selAddr;
   logic [COLOR_W-1:0] w_selColor;
   logic               w_outOfRange;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arbiter (
      .i_pending   (r_pending),
      .i_lastGrant (r_lastGrant),
      .o_pick      (w_pick),
      .o_pickIdx   (w_pickIdx)
   );

   assign w_selAddr    = bus.req_addr[int'(w_pickIdx)*ADDR_W +: ADDR_W];
   assign w_selColor   = bus.req_color[int'(w_pickIdx)*COLOR_W +: COLOR_W];
   assign w_outOfRange = (w_selAddr < L_MIN) || (w_selAddr >= L_LIMIT);

   // Frame sequencer; the anchor floor keeps the drawer's upward row offsets from wrapping
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_lastGrant  <= L_LAST_REQ;
         r_clrAddr    <= '0;
         r_waitCnt    <= '0;
         r_grant      <= '0;
         r_drawStart  <= 1'b0;
         r_drawAddr   <= '0;
         r_drawColor  <= '0;
         r_frameBusy  <= 1'b0;
         r_frameDone  <= 1'b0;
         r_errOverrun <= 1'b0;
         r_errBounds  <= 1'b0;
         r_errTimeout <= 1'b0;
      end else begin
         r_grant     <= '0;
         r_drawStart <= 1'b0;
         r_frameDone <= 1'b0;
         if (bus.frame_start && (r_state != S_IDLE)) r_errOverrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.frame_start) begin
                  r_pending   <= bus.req;
                  r_clrAddr   <= '0;
                  r_frameBusy <= 1'b1;
                  r_state     <= CLEAR_EN ? S_CLEAR : S_ARB;
               end
            end
            S_CLEAR: begin
               if (r_clrAddr == L_CLR_LAST) r_state <= S_ARB;
               else                         r_clrAddr <= r_clrAddr + 1'b1;
            end
            S_ARB: begin
               if (r_pending == '0) begin
                  r_frameDone <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_pending   <= r_pending & ~w_pick;
                  r_lastGrant <= w_pickIdx;
                  if (w_outOfRange) begin
                     r_errBounds <= 1'b1;
                  end else begin
                     r_drawAddr  <= w_selAddr;
                     r_drawColor <= w_selColor;
                     r_grant     <= w_pick;
                     r_drawStart <= 1'b1;
                     r_state     <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               r_waitCnt <= '0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // draw_done is stale from the previous sprite on the first WAIT cycle
               if ((r_waitCnt != '0) && bus.draw_done) begin
                  r_state <= S_ARB;
               end else if (r_waitCnt == L_WD_LAST) begin
                  r_errTimeout <= 1'b1;
                  r_state      <= S_ARB;
               end else begin
                  r_waitCnt <= r_waitCnt + 1'b1;
               end
            end
            S_DONE: begin
               r_frameBusy <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Registered write mux; the drawer keeps wenable high after finishing, so only LAUNCH/WAIT pass it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_memWaddr <= '0;
         r_memWdata <= '0;
         r_memWen   <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_memWaddr <= r_clrAddr;
               r_memWdata <= BG_COLOR;
               r_memWen   <= 1'b1;
            end
            S_LAUNCH, S_WAIT: begin
               r_memWaddr <= bus.drw_waddr;
               r_memWdata <= r_drawColor;
               r_memWen   <= bus.drw_wenable;
            end
            default: begin
               r_memWaddr <= '0;
               r_memWdata <= '0;
               r_memWen   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant       = r_grant;
   assign bus.draw_start  = r_drawStart;
   assign bus.draw_addr   = r_drawAddr;
   assign bus.draw_color  = r_drawColor;
   assign bus.mem_waddr   = r_memWaddr;
   assign bus.mem_wdata   = r_memWdata;
   assign bus.mem_wenable = r_memWen;
   assign bus.frame_busy  = r_frameBusy;
   assign bus.frame_done  = r_frameDone;
   assign bus.err_overrun = r_errOverrun;
   assign bus.err_bounds  = r_errBounds;
   assign bus.err_timeout = r_errTimeout;

endmodule
